// File: rtl/ws2812_pkg.sv
// Shared constants, FSM state encoding and colour reordering helper for the
// WS2812 frame transmitter.
package ws2812_pkg;

    localparam int NUM_LEDS     = 11;
    localparam int BITS_PER_LED = 24;
    localparam int FRAME_BITS   = NUM_LEDS * BITS_PER_LED;  // 264

    // Default timing at 50 MHz.
    localparam int T_BIT_DEF   = 62;     // 1.25 us per data bit
    localparam int T0H_DEF     = 20;     // 0.4 us high for a '0'
    localparam int T1H_DEF     = 40;     // 0.8 us high for a '1'
    localparam int T_RESET_DEF = 15000;  // 300 us latch interval

    // FSM state encoding, kept as plain constants so older tools can read it.
    typedef logic [2:0] estado_t;
    localparam estado_t OCIOSO = 3'd0;
    localparam estado_t ALTO   = 3'd1;
    localparam estado_t BAIXO  = 3'd2;
    localparam estado_t LATCH  = 3'd3;
    localparam estado_t FIM    = 3'd4;

    // The datapath delivers {R,G,B}; the strip expects G first, then R, then B.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_frame_tx_if.sv
// Bundle of start/status/colour signals between the game datapath and the
// WS2812 frame transmitter, plus the FSM state for observation.
//
// Handshake: 'inicia' is a single-cycle start request. It is accepted only
// when 'ocupado' is low and the FSM is idle; requests while busy (or in the
// cycle 'pronto' is high) are dropped, never queued. The led words are
// sampled in the accepting cycle only. 'ocupado' stays high from the accept
// edge until the edge where 'pronto' pulses for exactly one cycle.
interface ws2812_frame_tx_if;
    import ws2812_pkg::*;

    logic        inicia;
    logic [23:0] led0;
    logic [23:0] led1;
    logic [23:0] led2;
    logic [23:0] led3;
    logic [23:0] led4;
    logic [23:0] led5;
    logic [23:0] led6;
    logic [23:0] led7;
    logic [23:0] led8;
    logic [23:0] led9;
    logic [23:0] led10;
    logic        dout;
    logic        ocupado;
    logic        pronto;
    estado_t     estado;

    // Datapath side: issues start and colour words, observes status.
    modport master (
        output inicia, led0, led1, led2, led3, led4, led5, led6, led7, led8, led9, led10,
        input  dout, ocupado, pronto, estado
    );

    // Transmitter side.
    modport slave (
        input  inicia, led0, led1, led2, led3, led4, led5, led6, led7, led8, led9, led10,
        output dout, ocupado, pronto, estado
    );

endinterface

// File: rtl/ws2812_bit_gen.sv
// Generates one WS2812 data-bit waveform: high for T1H or T0H cycles
// depending on 'bit_val', then low until T_BIT cycles have elapsed.
// 'carrega' starts a bit (dout rises at that edge); 'fim_alto' flags the
// last high cycle and 'fim_bit' flags the last cycle of the bit period.
module ws2812_bit_gen #(
    parameter int T_BIT = 62,
    parameter int T0H   = 20,
    parameter int T1H   = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic carrega,
    input  logic bit_val,
    output logic dout,
    output logic fim_alto,
    output logic fim_bit
);

    localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;

    logic [CW-1:0] cnt;
    logic          ativo;
    logic [CW-1:0] ultimo_alto;

    // bit_val is held stable by the caller for the whole bit period.
    assign ultimo_alto = bit_val ? CW'(T1H - 1) : CW'(T0H - 1);
    assign fim_alto    = ativo && (cnt == ultimo_alto);
    assign fim_bit     = ativo && (cnt == CW'(T_BIT - 1));

    // Cycle counter and registered line level for the current bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            ativo <= 1'b0;
            dout  <= 1'b0;
        end else if (carrega) begin
            cnt   <= '0;
            ativo <= 1'b1;
            dout  <= 1'b1;
        end else if (ativo) begin
            if (fim_bit) begin
                cnt   <= '0;
                ativo <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (fim_alto) begin
                dout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: snapshots 11 colour words on 'inicia', sends
// them as 264 NRZ bits (led0 first, GRB order, MSB first), holds the line
// low for the latch interval and pulses 'pronto'.
module ws2812_frame_tx
    import ws2812_pkg::*;
#(
    parameter int T_BIT   = T_BIT_DEF,
    parameter int T0H     = T0H_DEF,
    parameter int T1H     = T1H_DEF,
    parameter int T_RESET = T_RESET_DEF
) (
    input  logic              clock,
    input  logic              reset,
    ws2812_frame_tx_if.slave  bus
);

    localparam int            LW         = (T_RESET > 1) ? $clog2(T_RESET + 1) : 1;
    localparam logic [8:0]    ULTIMO_BIT = 9'(FRAME_BITS - 1);

    logic [23:0]           led [NUM_LEDS];
    logic [FRAME_BITS-1:0] frame_in;
    logic [FRAME_BITS-1:0] sr;
    logic [8:0]            bit_cnt;
    logic [LW-1:0]         lcnt;
    estado_t               estado;
    estado_t               estado_prox;
    logic                  inicio;
    logic                  proximo_bit;
    logic                  carrega;
    logic                  fim_alto;
    logic                  fim_bit;
    logic                  dout_bit;

    assign led[0]  = bus.led0;
    assign led[1]  = bus.led1;
    assign led[2]  = bus.led2;
    assign led[3]  = bus.led3;
    assign led[4]  = bus.led4;
    assign led[5]  = bus.led5;
    assign led[6]  = bus.led6;
    assign led[7]  = bus.led7;
    assign led[8]  = bus.led8;
    assign led[9]  = bus.led9;
    assign led[10] = bus.led10;

    // Assemble the wire-order frame: led0 in the top 24 bits, each in GRB.
    always_comb begin
        frame_in = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            frame_in[FRAME_BITS-1-i*BITS_PER_LED -: BITS_PER_LED] = rgb_to_grb(led[i]);
        end
    end

    // A start is only honoured from idle; the next bit is loaded at the end
    // of each bit period except the last.
    assign inicio      = (estado == OCIOSO) && bus.inicia;
    assign proximo_bit = (estado == BAIXO) && fim_bit && (bit_cnt != ULTIMO_BIT);
    assign carrega     = inicio || proximo_bit;

    // The bit on the wire is always the top of the shift register.
    ws2812_bit_gen #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_gen (
        .clock    (clock),
        .reset    (reset),
        .carrega  (carrega),
        .bit_val  (sr[FRAME_BITS-1]),
        .dout     (dout_bit),
        .fim_alto (fim_alto),
        .fim_bit  (fim_bit)
    );

    // Next-state decode for the frame FSM.
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: if (bus.inicia) estado_prox = ALTO;
            ALTO:   if (fim_alto)   estado_prox = BAIXO;
            BAIXO:  if (fim_bit)    estado_prox = (bit_cnt == ULTIMO_BIT) ? LATCH : ALTO;
            LATCH:  if (lcnt == LW'(T_RESET - 1)) estado_prox = FIM;
            FIM:    estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    // State register, frame snapshot/shift register, bit counter and latch timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            sr      <= '0;
            bit_cnt <= '0;
            lcnt    <= '0;
        end else begin
            estado <= estado_prox;
            if (inicio) begin
                sr      <= frame_in;
                bit_cnt <= '0;
            end else if (proximo_bit) begin
                sr      <= {sr[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (estado == LATCH) begin
                lcnt <= lcnt + 1'b1;
            end else begin
                lcnt <= '0;
            end
        end
    end

    assign bus.dout    = dout_bit;
    assign bus.ocupado = (estado == ALTO) || (estado == BAIXO) || (estado == LATCH);
    assign bus.pronto  = (estado == FIM);
    assign bus.estado  = estado;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Directed bench for ws2812_frame_tx with short timing (T_BIT=10, T0H=3,
// T1H=7, T_RESET=20). Each frame is captured cycle by cycle and decoded.
module tb_ws2812_frame_tx;
    import ws2812_pkg::*;

    localparam int TB_T_BIT = 10;
    localparam int TB_TOTAL = 264 * TB_T_BIT + 20;  // 2660
    localparam int MAXN     = 2720;

    logic clk;
    logic reset;
    logic [23:0] led_v [11];

    int errors;
    int checks;

    logic s_dout  [MAXN];
    logic s_ocup  [MAXN];
    logic s_pronto[MAXN];

    ws2812_frame_tx_if bus_if ();

    assign bus_if.led0  = led_v[0];
    assign bus_if.led1  = led_v[1];
    assign bus_if.led2  = led_v[2];
    assign bus_if.led3  = led_v[3];
    assign bus_if.led4  = led_v[4];
    assign bus_if.led5  = led_v[5];
    assign bus_if.led6  = led_v[6];
    assign bus_if.led7  = led_v[7];
    assign bus_if.led8  = led_v[8];
    assign bus_if.led9  = led_v[9];
    assign bus_if.led10 = led_v[10];

    ws2812_frame_tx #(
        .T_BIT   (10),
        .T0H     (3),
        .T1H     (7),
        .T_RESET (20)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected wire frame: led0 first, G,R,B each MSB first; bit 263 goes out first.
    function automatic logic [263:0] build_frame(input logic [23:0] w [11]);
        logic [263:0] f;
        f = '0;
        for (int i = 0; i < 11; i++) begin
            f[263 - 24*i -: 24] = {w[i][15:8], w[i][23:16], w[i][7:0]};
        end
        return f;
    endfunction

    task automatic set_all(input logic [23:0] v);
        for (int i = 0; i < 11; i++) led_v[i] = v;
    endtask

    // Pulse inicia and record dout/ocupado/pronto for n cycles; sample j is
    // taken j cycles after the accepting edge. Optional mid-frame actions.
    task automatic capture(input int n, input int chg_at, input int ini_at,
                           input int ini_len, input int rst_at);
        @(negedge clk);
        bus_if.inicia = 1'b1;
        @(negedge clk);
        bus_if.inicia = 1'b0;
        for (int j = 0; j < n; j++) begin
            s_dout[j]   = bus_if.dout;
            s_ocup[j]   = bus_if.ocupado;
            s_pronto[j] = bus_if.pronto;
            if (j == chg_at) set_all(24'hFFFFFF);
            if (j == ini_at) bus_if.inicia = 1'b1;
            if (j == ini_at + ini_len) bus_if.inicia = 1'b0;
            if (j == rst_at) reset = 1'b1;
            if (j == rst_at + 1) reset = 1'b0;
            @(negedge clk);
        end
        bus_if.inicia = 1'b0;
    endtask

    // Turn captured samples into bits; a period whose high run is neither
    // 3 nor 7 cycles, or that goes high again after falling, counts as bad.
    task automatic decode(output logic [263:0] bits, output int bad);
        int len;
        logic seen0;
        bits = '0;
        bad  = 0;
        for (int n = 0; n < 264; n++) begin
            len   = 0;
            seen0 = 1'b0;
            for (int c = 0; c < TB_T_BIT; c++) begin
                if (s_dout[n*TB_T_BIT + c] && !seen0) len++;
                else if (s_dout[n*TB_T_BIT + c] && seen0) bad++;
                else seen0 = 1'b1;
            end
            if (len == 7) bits[263 - n] = 1'b1;
            else if (len != 3) bad++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.inicia = 1'b0;
        set_all(24'h0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.dout, bus_if.ocupado, bus_if.pronto} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000", {bus_if.dout, bus_if.ocupado, bus_if.pronto});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_if.estado !== OCIOSO || bus_if.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: estado=%0d ocupado=%b required 0/0", bus_if.estado, bus_if.ocupado);
        end
    endtask

    task automatic test_all_zero();
        logic [263:0] bits;
        int bad;
        int n_ocup;
        int n_pronto;
        set_all(24'h0);
        capture(2700, -1, -1, 0, -1);
        decode(bits, bad);
        n_ocup = 0;
        n_pronto = 0;
        for (int j = 0; j < 2700; j++) begin
            n_ocup += s_ocup[j];
            n_pronto += s_pronto[j];
        end
        checks++;
        if (s_dout[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_start_latency: got dout=%b required 1", s_dout[0]);
        end
        checks++;
        if (bad !== 0 || bits !== 264'h0) begin
            errors++;
            $display("FAIL zero_bits: bad=%0d bits=%h required 0 bad, all zero", bad, bits);
        end
        checks++;
        if (n_ocup !== TB_TOTAL) begin
            errors++;
            $display("FAIL zero_ocupado_len: got %0d required %0d", n_ocup, TB_TOTAL);
        end
        checks++;
        if (s_ocup[TB_TOTAL-1] !== 1'b1 || s_ocup[TB_TOTAL] !== 1'b0) begin
            errors++;
            $display("FAIL zero_ocupado_fall: got %b%b required 10", s_ocup[TB_TOTAL-1], s_ocup[TB_TOTAL]);
        end
        checks++;
        if (n_pronto !== 1 || s_pronto[TB_TOTAL] !== 1'b1) begin
            errors++;
            $display("FAIL zero_pronto: count=%0d at_2660=%b required 1/1", n_pronto, s_pronto[TB_TOTAL]);
        end
    endtask

    task automatic test_red();
        logic [263:0] bits;
        int bad;
        set_all(24'h0);
        led_v[0] = 24'hFF0000;
        capture(2700, -1, -1, 0, -1);
        decode(bits, bad);
        checks++;
        if (bad !== 0 || bits !== {8'h00, 8'hFF, 248'h0}) begin
            errors++;
            $display("FAIL red_bits: bad=%0d bits=%h required %h", bad, bits, {8'h00, 8'hFF, 248'h0});
        end
    endtask

    task automatic test_last_bit();
        logic [263:0] bits;
        int bad;
        int hi;
        set_all(24'h0);
        led_v[10] = 24'h000001;
        capture(2700, -1, -1, 0, -1);
        decode(bits, bad);
        hi = 0;
        for (int j = 2640; j < 2660; j++) hi += s_dout[j];
        checks++;
        if (bad !== 0 || bits !== 264'h1) begin
            errors++;
            $display("FAIL last_bit: bad=%0d bits=%h required 1", bad, bits);
        end
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL latch_low: got %0d high cycles required 0", hi);
        end
        checks++;
        if (s_pronto[TB_TOTAL] !== 1'b1 || s_pronto[TB_TOTAL-1] !== 1'b0) begin
            errors++;
            $display("FAIL last_pronto_edge: got %b%b required 01", s_pronto[TB_TOTAL-1], s_pronto[TB_TOTAL]);
        end
    endtask

    task automatic test_snapshot();
        logic [263:0] bits;
        logic [263:0] exp_frame;
        int bad;
        int n_ocup;
        for (int i = 0; i < 11; i++) led_v[i] = 24'h0F0000 + 24'(i * 24'h010203);
        led_v[0] = 24'h123456;
        exp_frame = build_frame(led_v);
        capture(2700, 50, 100, 1, -1);
        decode(bits, bad);
        n_ocup = 0;
        for (int j = 0; j < 2700; j++) n_ocup += s_ocup[j];
        checks++;
        if (bits[263:240] !== 24'h341256) begin
            errors++;
            $display("FAIL snap_led0_grb: got %h required 341256", bits[263:240]);
        end
        checks++;
        if (bad !== 0 || bits !== exp_frame) begin
            errors++;
            $display("FAIL snap_frame: bad=%0d bits=%h required %h", bad, bits, exp_frame);
        end
        checks++;
        if (n_ocup !== TB_TOTAL || s_pronto[TB_TOTAL] !== 1'b1) begin
            errors++;
            $display("FAIL snap_ocupado: len=%0d pronto=%b required %0d/1", n_ocup, s_pronto[TB_TOTAL], TB_TOTAL);
        end
    endtask

    task automatic test_back_to_back();
        set_all(24'h0);
        capture(2670, -1, TB_TOTAL, 2, -1);
        checks++;
        if (s_pronto[TB_TOTAL] !== 1'b1 || s_ocup[TB_TOTAL+1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: pronto=%b ocupado_next=%b required 1/0", s_pronto[TB_TOTAL], s_ocup[TB_TOTAL+1]);
        end
        checks++;
        if (s_ocup[TB_TOTAL+2] !== 1'b1 || s_dout[TB_TOTAL+2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: ocupado=%b dout=%b required 1/1", s_ocup[TB_TOTAL+2], s_dout[TB_TOTAL+2]);
        end
        pulse_reset();
    endtask

    task automatic test_reset_midframe();
        logic [263:0] bits;
        logic [263:0] exp_frame;
        int bad;
        set_all(24'hFFFFFF);
        capture(1005, -1, -1, 0, 1000);
        checks++;
        if ({s_dout[1001], s_ocup[1001], s_pronto[1001]} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b required 000", {s_dout[1001], s_ocup[1001], s_pronto[1001]});
        end
        for (int i = 0; i < 11; i++) led_v[i] = 24'hA50000 + 24'(i * 24'h001111);
        exp_frame = build_frame(led_v);
        capture(2700, -1, -1, 0, -1);
        decode(bits, bad);
        checks++;
        if (bad !== 0 || bits !== exp_frame) begin
            errors++;
            $display("FAIL midreset_frame: bad=%0d bits=%h required %h", bad, bits, exp_frame);
        end
        checks++;
        if (s_pronto[TB_TOTAL] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pronto: got %b required 1", s_pronto[TB_TOTAL]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus_if.inicia = 1'b0;
        test_reset();
        test_all_zero();
        test_red();
        test_last_bit();
        test_snapshot();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
